// File: rtl/comb_explorer_pkg.sv
// Shared glyphs, mode encoding and the bit-to-glyph helper for comb_explorer.
package comb_explorer_pkg;

    localparam logic [7:0] ZERO    = 8'b0011_1111;
    localparam logic [7:0] ONE     = 8'b0000_0110;
    localparam logic [7:0] BLANK   = 8'h00;
    localparam logic [7:0] GLYPH_S = 8'b0110_1101;
    localparam logic [7:0] GLYPH_A = 8'b0111_0111;

    typedef enum logic {
        STEP = 1'b0,
        AUTO = 1'b1
    } mode_t;

    function automatic logic [7:0] bit_glyph(input logic b);
        return b ? ONE : ZERO;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, stability counter, and a one-cycle press pulse
// on each accepted rising edge.
module key_debounce #(
    parameter int DEBOUNCE = 60000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          prev_q, prev_d;

    always_comb begin
        sync_d   = {sync_q[0], raw};
        prev_d   = stable_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
            // DEBOUNCE consecutive disagreeing samples: accept the new level.
            stable_d = sync_q[1];
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
        end
    end

    assign stable = stable_q;
    assign press  = stable_q & ~prev_q;

endmodule

// File: rtl/comb_explorer.sv
// Interactive N-input truth-table explorer for the TM1638 LED&Key board.
// Define COMB_EXPLORER_SWEEP_EN to build in the AUTO sweep mode on key 0.
module comb_explorer
    import comb_explorer_pkg::*;
#(
    parameter int                   N_IN         = 3,
    parameter logic [(1<<N_IN)-1:0] TRUTH        = 8'b1110_1000,
    parameter int                   DEBOUNCE     = 60000,
    parameter int                   SWEEP_PERIOD = 6000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] keys,
    output logic [7:0] display0,
    output logic [7:0] display1,
    output logic [7:0] display2,
    output logic [7:0] display3,
    output logic [7:0] display4,
    output logic [7:0] display5,
    output logic [7:0] display6,
    output logic [7:0] display7,
    output logic [7:0] leds
);

    genvar gi;

    logic [7:0]      stable_w, press_w;
    logic [N_IN-1:0] in_press;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            y;
    logic [7:0]      mode_glyph;
    logic [7:0]      leds_q, leds_d;
    logic            unused_keys;

    for (gi = 0; gi < 8; gi++) begin : g_key
        key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clock  (clock),
            .reset  (reset),
            .raw    (keys[gi]),
            .stable (stable_w[gi]),
            .press  (press_w[gi])
        );
    end

    // Input i lives on the key/digit/LED numbered 7-i.
    for (gi = 0; gi < N_IN; gi++) begin : g_in_press
        assign in_press[gi] = press_w[7-gi];
    end

    assign unused_keys = ^{stable_w, press_w};
    assign y = TRUTH[vec_q];

`ifdef COMB_EXPLORER_SWEEP_EN
    localparam int TW = $clog2(SWEEP_PERIOD);

    mode_t         mode_q, mode_d;
    logic [TW-1:0] tick_q, tick_d;

    always_comb begin
        vec_d  = vec_q;
        mode_d = mode_q;
        tick_d = tick_q;
        if (mode_q == STEP) begin
            vec_d = vec_q ^ in_press;
        end
        // A mode toggle takes priority over a wrapping tick.
        if (press_w[0]) begin
            mode_d = (mode_q == STEP) ? AUTO : STEP;
            tick_d = '0;
        end else if (mode_q == AUTO) begin
            if (tick_q == TW'(SWEEP_PERIOD - 1)) begin
                tick_d = '0;
                vec_d  = vec_q + N_IN'(1);
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q <= STEP;
            tick_q <= '0;
        end else begin
            mode_q <= mode_d;
            tick_q <= tick_d;
        end
    end

    assign mode_glyph = (mode_q == AUTO) ? GLYPH_A : GLYPH_S;
`else
    always_comb begin
        vec_d = vec_q ^ in_press;
    end

    assign mode_glyph = GLYPH_S;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    for (gi = 0; gi < 8; gi++) begin : g_dig
        logic [7:0] dig_d, dig_q, dig_rst;
        if (gi == 0) begin : g_y
            assign dig_d       = bit_glyph(y);
            assign dig_rst     = bit_glyph(TRUTH[0]);
            assign leds_d[gi]  = y;
        end else if (gi == 1) begin : g_mode
            assign dig_d       = mode_glyph;
            assign dig_rst     = GLYPH_S;
            assign leds_d[gi]  = 1'b0;
        end else if (gi >= 8 - N_IN) begin : g_input
            assign dig_d       = bit_glyph(vec_q[7-gi]);
            assign dig_rst     = ZERO;
            assign leds_d[gi]  = vec_q[7-gi];
        end else begin : g_blank
            assign dig_d       = BLANK;
            assign dig_rst     = BLANK;
            assign leds_d[gi]  = 1'b0;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                dig_q <= dig_rst;
            end else begin
                dig_q <= dig_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            leds_q <= {7'b0, TRUTH[0]};
        end else begin
            leds_q <= leds_d;
        end
    end

    assign display0 = g_dig[0].dig_q;
    assign display1 = g_dig[1].dig_q;
    assign display2 = g_dig[2].dig_q;
    assign display3 = g_dig[3].dig_q;
    assign display4 = g_dig[4].dig_q;
    assign display5 = g_dig[5].dig_q;
    assign display6 = g_dig[6].dig_q;
    assign display7 = g_dig[7].dig_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_comb_explorer.sv
// Scoreboard bench for comb_explorer: stimulus pushes predicted output snapshots,
// a negedge monitor pops one on every output change and checks value and cycle.
module tb_comb_explorer;

    localparam int D  = 4;
    localparam int SP = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] keys  = 8'h00;
    logic [7:0] display0, display1, display2, display3;
    logic [7:0] display4, display5, display6, display7;
    logic [7:0] leds;

    comb_explorer #(
        .DEBOUNCE     (D),
        .SWEEP_PERIOD (SP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .keys     (keys),
        .display0 (display0),
        .display1 (display1),
        .display2 (display2),
        .display3 (display3),
        .display4 (display4),
        .display5 (display5),
        .display6 (display6),
        .display7 (display7),
        .leds     (leds)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [71:0] val;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [71:0] last_obs;
    logic [2:0]  mvec   = 3'b000;
    bit          mauto  = 1'b0;
    int          e0;
    int          t_auto;

    wire [71:0] obs = {display7, display6, display5, display4,
                       display3, display2, display1, display0, leds};

    function automatic logic [7:0] glyph(input logic b);
        return b ? 8'h06 : 8'h3F;
    endfunction

    // Behavioural view: majority of three inputs, digit/LED placement by input index.
    function automatic logic [71:0] model_snap(input logic [2:0] v, input bit auto_m);
        logic [7:0] d [8];
        logic [7:0] l;
        logic       yy;
        yy = ($countones(v) >= 2);
        for (int k = 0; k < 8; k++) d[k] = 8'h00;
        d[0] = glyph(yy);
        d[1] = auto_m ? 8'h77 : 8'h6D;
        l    = 8'h00;
        l[0] = yy;
        for (int i = 0; i < 3; i++) begin
            d[7-i] = glyph(v[i]);
            l[7-i] = v[i];
        end
        return {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0], l};
    endfunction

    function automatic logic [7:0] in_keys(input logic [2:0] m);
        return {m[0], m[1], m[2], 5'b00000};
    endfunction

    task automatic push(input int due);
        exp_t e;
        e.due = due;
        e.val = model_snap(mvec, mauto);
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_at(input int e, input logic [7:0] v);
        if (e - 1 > cyc) tick(e - 1 - cyc);
        keys = v;
    endtask

    task automatic check_now(input string name);
        logic [71:0] want;
        want = model_snap(mvec, mauto);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, obs, want);
        end
    endtask

    // Press the input keys in m together, hold, release; each pressed input toggles.
    task automatic step_press(input logic [2:0] m, input int hold);
        int s;
        s    = cyc + 1;
        keys = keys | in_keys(m);
        mvec = mvec ^ m;
        push(s + 3 + D);
        tick(hold);
        keys = keys & ~in_keys(m);
        tick(D + 4);
    endtask

    always @(negedge clock) begin
        if (!mon_en) begin
            last_obs = obs;
        end else if (obs !== last_obs) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change at cycle %0d: got %h, expected unchanged %h",
                         cyc, obs, last_obs);
            end else begin
                mon_e = sbq.pop_front();
                if (obs !== mon_e.val || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL output_change at cycle %0d: got %h, expected %h at cycle %0d",
                             cyc, obs, mon_e.val, mon_e.due);
                end
            end
            last_obs = obs;
        end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
            checks++;
            errors++;
            mon_e = sbq.pop_front();
            $display("FAIL missed_change at cycle %0d: got %h, expected %h at cycle %0d",
                     cyc, obs, mon_e.val, mon_e.due);
        end
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(3);
        check_now("reset_state");
        mon_en = 1'b1;

        step_press(3'b001, 10);
        step_press(3'b110, 6);
        check_now("multi_press");

        // Key 6 bounce, 3-cycle pulses, never long enough to be accepted.
        for (int p = 0; p < 3; p++) begin
            keys[6] = 1'b1;
            tick(3);
            keys[6] = 1'b0;
            tick(3);
        end
        tick(D + 4);
        check_now("bounce_ignored");
        step_press(3'b010, 8);
        check_now("after_bounce");

        for (int r = 0; r < 8; r++) begin
            logic [2:0] m;
            int         h;
            m = 3'($urandom_range(1, 7));
            h = int'($urandom_range(D, D + 6));
            step_press(m, h);
        end
        tick(4);
        check_now("random_steps");

`ifdef COMB_EXPLORER_SWEEP_EN
        if (mvec != 3'b000) step_press(mvec, 6);
        check_now("vec_zero");

        e0      = cyc + 1;
        keys[0] = 1'b1;
        t_auto  = e0 + 2 + D;
        mauto   = 1'b1;
        push(t_auto + 1);
        for (int m = 1; m <= 8; m++) begin
            mvec = mvec + 3'd1;
            push(t_auto + m * SP + 1);
        end
        tick(8);
        keys[0] = 1'b0;

        drive_at(t_auto + 20, 8'h80);
        tick(6);
        keys = 8'h00;

        // Mode toggle lands on the wrapping tick edge: no increment.
        drive_at(t_auto + 9 * SP - 2 - D, 8'h01);
        mauto = 1'b0;
        push(t_auto + 9 * SP + 1);
        tick(8);
        keys = 8'h00;
        tick(D + 4 + 2 * SP);
        check_now("toggle_on_wrap");

        e0      = cyc + 1;
        keys[0] = 1'b1;
        t_auto  = e0 + 2 + D;
        mauto   = 1'b1;
        push(t_auto + 1);
        for (int m = 1; m <= 3; m++) begin
            mvec = mvec + 3'd1;
            push(t_auto + m * SP + 1);
        end
        tick(8);
        keys[0] = 1'b0;
        drive_at(t_auto + 35, 8'h00);
        reset = 1'b1;
        mvec  = 3'b000;
        mauto = 1'b0;
        push(t_auto + 35);
        tick(2);
        reset = 1'b0;
        tick(2 * SP);
        check_now("reset_mid_sweep");
`else
        keys[0] = 1'b1;
        tick(D + 6);
        keys[0] = 1'b0;
        tick(D + 6);
        check_now("key0_ignored");

        if (mvec == 3'b000) step_press(3'b001, 6);
        reset = 1'b1;
        mvec  = 3'b000;
        push(cyc + 1);
        tick(2);
        reset = 1'b0;
        tick(10);
        check_now("reset_mid_run");
`endif

        tick(20);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected changes outstanding, expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
